seq_alu: RTL

- Parametrised successor to the datapath ALU for the multi-cycle CPU.
- Keeps the single-cycle logic/arithmetic ops and adds carry/overflow/negative flags, barrel shifts, and an iterative multiply and divide.
- Operands are captured on a start/busy/done handshake. The controller FSM issues an op and waits for done before writing the result back.

---
 rtl/seq_alu.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic/shift ops plus iterative
// shift-add multiply and restoring divide, behind a start/busy/done handshake.
module seq_alu #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   opc,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] res,
  output logic [N-1:0] res_hi,
  output logic         zero,
  output logic         neg,
  output logic         carry,
  output logic         ovf,
  output logic         dz
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NOT  = 4'd4,
    OP_PASA = 4'd5,
    OP_PASB = 4'd6,
    OP_XOR  = 4'd7,
    OP_MULU = 4'd8,
    OP_DIVU = 4'd9,
    OP_SHL  = 4'd10,
    OP_SAR  = 4'd11,
    OP_SLT  = 4'd12
  } opc_t;

  state_t        st;
  logic [CW-1:0] cnt;
  logic [N-1:0]  op_x;
  logic [N-1:0]  acc_hi;
  logic [N-1:0]  acc_lo;

  logic [CW-2:0]      sh;
  logic [N:0]         add_sum;
  logic [N:0]         sub_dif;
  logic [N:0]         shl_ext;
  logic signed [N:0]  sar_ext;
  logic [N-1:0]       f_res;
  logic [N-1:0]       f_hi;
  logic               f_carry;
  logic               f_ovf;
  logic               f_dz;
  logic               go_iter;

  logic [N:0]   mul_sum;
  logic [N:0]   div_dif;
  logic [N-1:0] div_sh;
  logic [N-1:0] step_hi;
  logic [N-1:0] step_lo;

  assign sh      = b[CW-2:0];
  assign go_iter = (opc == OP_MULU) || ((opc == OP_DIVU) && (b != '0));

  always_comb begin
    add_sum = {1'b0, a} + {1'b0, b};
    sub_dif = {1'b0, a} - {1'b0, b};
    shl_ext = {1'b0, a} << sh;
    // Extra guard bit below the LSB catches the last bit shifted out.
    sar_ext = $signed({a, 1'b0}) >>> sh;
    f_res   = '0;
    f_hi    = '0;
    f_carry = 1'b0;
    f_ovf   = 1'b0;
    f_dz    = 1'b0;
    case (opc)
      OP_ADD: begin
        f_res   = add_sum[N-1:0];
        f_carry = add_sum[N];
        f_ovf   = (a[N-1] == b[N-1]) && (add_sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        f_res   = sub_dif[N-1:0];
        f_carry = ~sub_dif[N];
        f_ovf   = (a[N-1] != b[N-1]) && (sub_dif[N-1] != a[N-1]);
      end
      OP_AND:  f_res = a & b;
      OP_OR:   f_res = a | b;
      OP_NOT:  f_res = ~a;
      OP_PASA: f_res = a;
      OP_PASB: f_res = b;
      OP_XOR:  f_res = a ^ b;
      OP_DIVU: begin
        f_res = '1;
        f_hi  = a;
        f_dz  = 1'b1;
      end
      OP_SHL: begin
        f_res   = shl_ext[N-1:0];
        f_carry = shl_ext[N];
      end
      OP_SAR: begin
        f_res   = sar_ext[N:1];
        f_carry = sar_ext[0];
      end
      OP_SLT:  f_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      default: ;
    endcase
  end

  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_x} : '0);
    div_dif = {acc_hi, acc_lo[N-1]} - {1'b0, op_x};
    div_sh  = {acc_hi[N-2:0], acc_lo[N-1]};
    if (st == MUL) begin
      step_hi = mul_sum[N:1];
      step_lo = {mul_sum[0], acc_lo[N-1:1]};
    end else if (!div_dif[N]) begin
      step_hi = div_dif[N-1:0];
      step_lo = {acc_lo[N-2:0], 1'b1};
    end else begin
      step_hi = div_sh;
      step_lo = {acc_lo[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      cnt    <= '0;
      op_x   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      res    <= '0;
      res_hi <= '0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          if (start && go_iter) begin
            st     <= (opc == OP_MULU) ? MUL : DIV;
            busy   <= 1'b1;
            cnt    <= CW'(N);
            op_x   <= (opc == OP_MULU) ? a : b;
            acc_lo <= (opc == OP_MULU) ? b : a;
            acc_hi <= '0;
          end else if (start) begin
            done   <= 1'b1;
            res    <= f_res;
            res_hi <= f_hi;
            zero   <= (f_res == '0);
            neg    <= f_res[N-1];
            carry  <= f_carry;
            ovf    <= f_ovf;
            dz     <= f_dz;
          end
        end
        MUL, DIV: begin
          cnt    <= cnt - CW'(1);
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          // Last step: publish the step result directly rather than waiting a cycle.
          if (cnt == CW'(1)) begin
            st     <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            res    <= step_lo;
            res_hi <= step_hi;
            zero   <= (step_lo == '0);
            neg    <= step_lo[N-1];
            carry  <= 1'b0;
            ovf    <= 1'b0;
            dz     <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
